// File: rtl/bram_scan_ctrl.sv
// Scan controller: reads CMD_COUNT words from a memory starting at CMD_BASE and streams them out.
// Optional macro BRAM_SCAN_CSUM_EN adds a CSUM port carrying the XOR of the accepted beats.
module bram_scan_ctrl #(
  parameter int addr_width = 1,
  parameter int data_width = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_START,
  input  logic [addr_width-1:0] CMD_BASE,
  input  logic [addr_width:0]   CMD_COUNT,
  output logic                  CMD_RDY,
  output logic [addr_width-1:0] MEM_RD_ADDR,
  output logic                  MEM_RD_EN,
  input  logic                  MEM_RD_RDY,
  input  logic [data_width-1:0] MEM_DOUT,
  input  logic                  MEM_DOUT_RDY,
  output logic                  MEM_DOUT_EN,
  output logic [data_width-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  output logic                  OUT_LAST,
  input  logic                  OUT_EN,
  output logic                  DONE
`ifdef BRAM_SCAN_CSUM_EN
  ,
  output logic [data_width-1:0] CSUM
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [addr_width-1:0] A_ONE  = addr_width'(1);
  localparam logic [addr_width:0]   C_ONE  = (addr_width + 1)'(1);
  localparam logic [addr_width:0]   C_ZERO = '0;

  state_t                r_state;
  logic                  r_armed;
  logic [addr_width-1:0] r_addr;
  logic [addr_width:0]   r_iss_left;
  logic [addr_width:0]   r_deq_left;
  logic [addr_width:0]   r_acc_left;
  logic [1:0]            r_outstanding;
  logic [data_width-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_done;
`ifdef BRAM_SCAN_CSUM_EN
  logic [data_width-1:0] r_csum;
`endif

  logic w_issue;
  logic w_deq;
  logic w_accept;
  logic w_finish;

  // Handshakes: a read is issued on an edge where MEM_RD_EN=1 (only ever raised with MEM_RD_RDY=1),
  // a response is dequeued on an edge where MEM_DOUT_EN=1, a beat is accepted where OUT_VALID=1 and OUT_EN=1.
  assign w_issue  = (r_state == ISSUE) && r_armed && MEM_RD_RDY && (r_outstanding < 2'd2);
  assign w_deq    = MEM_DOUT_RDY && (!r_out_valid || OUT_EN);
  assign w_accept = r_out_valid && OUT_EN;
  assign w_finish = (r_state == DRAIN) && (r_outstanding == 2'd0) &&
                    ((r_acc_left == C_ZERO) || ((r_acc_left == C_ONE) && w_accept));

  assign CMD_RDY     = RST || (r_state == IDLE);
  assign MEM_RD_ADDR = r_addr;
  assign MEM_RD_EN   = !RST && w_issue;
  assign MEM_DOUT_EN = !RST && w_deq;
  assign OUT_DATA    = r_out_data;
  assign OUT_VALID   = r_out_valid;
  assign OUT_LAST    = r_out_last;
  assign DONE        = r_done;
`ifdef BRAM_SCAN_CSUM_EN
  assign CSUM        = r_csum;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= IDLE;
      r_armed       <= 1'b0;
      r_addr        <= '0;
      r_iss_left    <= '0;
      r_deq_left    <= '0;
      r_acc_left    <= '0;
      r_outstanding <= 2'd0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_done        <= 1'b0;
`ifdef BRAM_SCAN_CSUM_EN
      r_csum        <= '0;
`endif
    end else begin
      r_done <= 1'b0;

      case ({w_issue, w_deq})
        2'b10:   r_outstanding <= r_outstanding + 2'd1;
        2'b01:   r_outstanding <= r_outstanding - 2'd1;
        default: ;
      endcase

      if (w_deq) begin
        r_out_data  <= MEM_DOUT;
        r_out_valid <= 1'b1;
        r_out_last  <= (r_deq_left == C_ONE);
        r_deq_left  <= r_deq_left - C_ONE;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end

      if (w_accept) begin
        r_acc_left <= r_acc_left - C_ONE;
`ifdef BRAM_SCAN_CSUM_EN
        r_csum     <= r_csum ^ r_out_data;
`endif
      end

      case (r_state)
        IDLE: begin
          r_armed <= 1'b0;
          if (CMD_START) begin
            r_addr     <= CMD_BASE;
            r_iss_left <= CMD_COUNT;
            r_deq_left <= CMD_COUNT;
            r_acc_left <= CMD_COUNT;
`ifdef BRAM_SCAN_CSUM_EN
            r_csum     <= '0;
`endif
            r_state    <= (CMD_COUNT == C_ZERO) ? DRAIN : ISSUE;
          end
        end
        // The first ISSUE cycle only arms the read port, so the first beat lands three cycles after start.
        ISSUE: begin
          r_armed <= 1'b1;
          if (w_issue) begin
            r_addr     <= r_addr + A_ONE;
            r_iss_left <= r_iss_left - C_ONE;
            if (r_iss_left == C_ONE) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_finish) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
